// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and response strings for the UART command executor.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PARSE,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [31:0] RESP_OK      = {"OK", ASCII_CR, ASCII_LF};
  localparam logic [3:0]  RESP_OK_LEN  = 4'd4;
  localparam logic [39:0] RESP_ERR     = {"ERR", ASCII_CR, ASCII_LF};
  localparam logic [3:0]  RESP_ERR_LEN = 4'd5;
  localparam logic [31:0] RESP_VER     = {"V1", ASCII_CR, ASCII_LF};
  localparam logic [3:0]  RESP_VER_LEN = 4'd4;

  // Responses are right-aligned in a 64-bit word; byte 0 is the leftmost used byte.
  function automatic logic [7:0] resp_byte(input logic [63:0] s, input logic [3:0] len,
                                           input logic [3:0] j);
    return s[8*(int'(len) - 1 - int'(j)) +: 8];
  endfunction

endpackage

// File: rtl/hex_ascii.sv
// Combinational nibble-to-uppercase-ASCII encoder plus ASCII-hex-digit decoder.
module hex_ascii
  import uart_cmd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] asc,
  input  logic [7:0] chr,
  output logic [3:0] val,
  output logic       valid
);

  logic [7:0] off;

  assign asc = (nib < 4'd10) ? ASCII_0 + {4'h0, nib} : ASCII_UA + {4'h0, nib} - 8'd10;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    off   = 8'h00;
    valid = 1'b0;
    if (chr >= ASCII_0 && chr <= ASCII_0 + 8'd9) begin
      off   = chr - ASCII_0;
      valid = 1'b1;
    end else if (chr >= ASCII_UA && chr <= ASCII_UA + 8'd5) begin
      off   = chr - ASCII_UA + 8'd10;
      valid = 1'b1;
    end else if (chr >= ASCII_LA && chr <= ASCII_LA + 8'd5) begin
      off   = chr - ASCII_LA + 8'd10;
      valid = 1'b1;
    end
  end

  assign val = off[3:0];

endmodule

// File: rtl/uart_cmd_exec.sv
// Reads a command line from the shared line buffer, decodes led/ver commands,
// writes the response string back and signals the handler.
module uart_cmd_exec
  import uart_cmd_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEN        = 256,
  parameter int RXSTR_BASE = 0,
  parameter int TXSTR_BASE = 128,
  localparam int AW        = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [AW-1:0]    cmd_len,
  output logic             msg_valid,
  output logic [AW-1:0]    msg_len,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_din,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_dout,
  output logic [7:0]       led,
  output logic             busy
);

  localparam logic [AW-1:0] RX_BASE = AW'(RXSTR_BASE);
  localparam logic [AW-1:0] TX_BASE = AW'(TXSTR_BASE);

  state_t           state;
  logic [2:0]       n_q;
  logic [2:0]       k_q;
  logic             long_q;
  logic [WIDTH-1:0] line_q [7];
  logic [3:0]       j_q;
  logic [63:0]      resp_q;
  logic [3:0]       resp_len_q;

  logic [63:0]      resp_c;
  logic [3:0]       resp_len_c;
  logic             led_set_c;
  logic             is_led, is_ver;
  logic [7:0]       hi_asc, lo_asc;
  logic [3:0]       hi_val, lo_val;
  logic             hi_ok, lo_ok;

  hex_ascii u_hex_hi (
    .nib   (led[7:4]),
    .asc   (hi_asc),
    .chr   (line_q[4]),
    .val   (hi_val),
    .valid (hi_ok)
  );

  hex_ascii u_hex_lo (
    .nib   (led[3:0]),
    .asc   (lo_asc),
    .chr   (line_q[5]),
    .val   (lo_val),
    .valid (lo_ok)
  );

  // Only bytes below n are ever inspected, and the length checks gate every match.
  always_comb begin
    is_led     = (line_q[0] == "l") && (line_q[1] == "e") && (line_q[2] == "d");
    is_ver     = (line_q[0] == "v") && (line_q[1] == "e") && (line_q[2] == "r");
    resp_c     = {24'h0, RESP_ERR};
    resp_len_c = RESP_ERR_LEN;
    led_set_c  = 1'b0;
    if (n_q == 3'd0) begin
      resp_c     = {48'h0, ASCII_CR, ASCII_LF};
      resp_len_c = 4'd2;
    end else if (long_q) begin
      resp_c     = {24'h0, RESP_ERR};
      resp_len_c = RESP_ERR_LEN;
    end else if (n_q == 3'd3 && is_led) begin
      resp_c     = {"LED=", hi_asc, lo_asc, ASCII_CR, ASCII_LF};
      resp_len_c = 4'd8;
    end else if (n_q == 3'd6 && is_led && line_q[3] == ASCII_SP && hi_ok && lo_ok) begin
      resp_c     = {32'h0, RESP_OK};
      resp_len_c = RESP_OK_LEN;
      led_set_c  = 1'b1;
    end else if (n_q == 3'd3 && is_ver) begin
      resp_c     = {32'h0, RESP_VER};
      resp_len_c = RESP_VER_LEN;
    end
  end

  // NOTE: the capture buffer has no reset; it is always refilled before PARSE reads it.
  always_ff @(posedge clk) begin
    if (state == ST_FETCH && k_q != 3'd0) begin
      line_q[k_q - 3'd1] <= mem_dout;
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch sees the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      long_q     <= 1'b0;
      j_q        <= '0;
      resp_q     <= '0;
      resp_len_q <= '0;
      msg_valid  <= 1'b0;
      msg_len    <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
      led        <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            n_q      <= (cmd_len > AW'(7)) ? 3'd7 : cmd_len[2:0];
            long_q   <= (cmd_len > AW'(6));
            k_q      <= '0;
            mem_addr <= RX_BASE;
            busy     <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Address k is presented while byte k-1 lands from the previous read.
          if (k_q == n_q) begin
            state <= ST_PARSE;
          end else begin
            k_q <= k_q + 3'd1;
            if (k_q + 3'd1 < n_q) mem_addr <= mem_addr + AW'(1);
          end
        end
        ST_PARSE: begin
          if (led_set_c) led <= {hi_val, lo_val};
          resp_q     <= resp_c;
          resp_len_q <= resp_len_c;
          j_q        <= '0;
          mem_addr   <= TX_BASE;
          mem_din    <= resp_byte(resp_c, resp_len_c, 4'd0);
          mem_we     <= 1'b1;
          state      <= ST_WRITE;
        end
        ST_WRITE: begin
          if (j_q == resp_len_q - 4'd1) begin
            mem_we    <= 1'b0;
            mem_din   <= '0;
            msg_valid <= 1'b1;
            msg_len   <= AW'(resp_len_q);
            state     <= ST_DONE;
          end else begin
            j_q      <= j_q + 4'd1;
            mem_addr <= mem_addr + AW'(1);
            mem_din  <= resp_byte(resp_q, resp_len_q, j_q + 4'd1);
          end
        end
        ST_DONE: begin
          msg_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_exec.sv
// Directed self-checking bench for uart_cmd_exec with a behavioural line-buffer model.
module tb_uart_cmd_exec;

  localparam int TX = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_len = '0;
  logic       msg_valid;
  logic [7:0] msg_len;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic       mem_we;
  logic [7:0] mem_dout;
  logic [7:0] led;
  logic       busy;

  logic [7:0] ram [256];
  logic [7:0] rd_q;
  logic       seen [128];
  int         vectors = 0;
  int         miscompares = 0;
  int         mv_count = 0;
  int         lat;

  uart_cmd_exec dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_len   (cmd_len),
    .msg_valid (msg_valid),
    .msg_len   (msg_len),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_dout  (mem_dout),
    .led       (led),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    rd_q <= ram[mem_addr];
  end
  assign mem_dout = rd_q;

  always @(negedge clk) begin
    if (msg_valid) mv_count++;
    if (busy && !mem_we && mem_addr < 8'd128) seen[mem_addr[6:0]] = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_cmd(input string s, input int len);
    for (int i = 0; i < s.len(); i++) ram[i] = s[i];
    for (int i = TX; i < 256; i++) ram[i] = 8'hEE;
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    mv_count = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_len   = 8'(len);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Latency is counted in edges from the one that sampled cmd_valid.
  task automatic wait_done(input string tag, output int l);
    l = -1;
    for (int j = 0; j < 200; j++) begin
      if (msg_valid) begin
        l = j + 1;
        break;
      end
      @(negedge clk);
    end
    if (l < 0) check({tag, "_timeout"}, 64'(0), 64'(1));
    for (int j = 0; j < 10 && busy; j++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_resp(input string tag, input string exp);
    for (int j = 0; j < exp.len(); j++)
      check($sformatf("%s_b%0d", tag, j), 64'(ram[TX+j]), 64'(exp[j]));
    check({tag, "_end"}, 64'(ram[TX+exp.len()]), 64'(8'hEE));
    check({tag, "_len"}, 64'(msg_len), 64'(exp.len()));
    check({tag, "_pulses"}, 64'(mv_count), 64'(1));
  endtask

  task automatic run(input string tag, input string s, input int len, input string exp,
                     input logic [7:0] exp_led);
    int n;
    n = (len > 7) ? 7 : len;
    start_cmd(s, len);
    wait_done(tag, lat);
    check_resp(tag, exp);
    check({tag, "_lat"}, 64'(lat), 64'(n + 3 + exp.len()));
    check({tag, "_led"}, 64'(led), 64'(exp_led));
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_msg_valid", 64'(msg_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_led", 64'(led), 64'(0));
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_din", 64'(mem_din), 64'(0));
    check("rst_msg_len", 64'(msg_len), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run("ver", "ver", 3, "V1\015\012", 8'h00);
    run("led_set", "led 5a", 6, "OK\015\012", 8'h5A);
    run("led_get", "led", 3, "LED=5A\015\012", 8'h5A);
    run("bad_hex", "led 5g", 6, "ERR\015\012", 8'h5A);
    run("lex", "lex", 3, "ERR\015\012", 8'h5A);
    run("long", "abcdefghijklmnopqrst", 20, "ERR\015\012", 8'h5A);
    cnt = 0;
    for (int i = 0; i < 128; i++) if (seen[i]) cnt++;
    check("long_reads", 64'(cnt), 64'(7));
    check("long_no_addr7", 64'(seen[7]), 64'(0));
    run("long7", "led 5ab", 7, "ERR\015\012", 8'h5A);
    run("empty", "", 0, "\015\012", 8'h5A);
    run("led_upper", "led C3", 6, "OK\015\012", 8'hC3);
    run("led_get2", "led", 3, "LED=C3\015\012", 8'hC3);

    // Reset while the response is being written.
    start_cmd("ver", 3);
    cnt = 0;
    while (!mem_we && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_mid_reach_write", 64'(mem_we), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_we", 64'(mem_we), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_led", 64'(led), 64'(0));
    check("rst_mid_msg_valid", 64'(msg_valid), 64'(0));
    check("rst_mid_addr", 64'(mem_addr), 64'(0));
    check("rst_mid_din", 64'(mem_din), 64'(0));
    check("rst_mid_partial0", 64'(ram[TX]), 64'("V"));
    check("rst_mid_partial1", 64'(ram[TX+1]), 64'(8'hEE));
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_mid_no_pulse", 64'(mv_count), 64'(0));
    run("ver_after_rst", "ver", 3, "V1\015\012", 8'h00);

    // Second cmd_valid while fetching must be ignored.
    start_cmd("ver", 3);
    cmd_valid = 1'b1;
    cmd_len   = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("dbl", lat);
    repeat (20) @(negedge clk);
    check("dbl_pulses", 64'(mv_count), 64'(1));
    check("dbl_busy", 64'(busy), 64'(0));
    check("dbl_len", 64'(msg_len), 64'(4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
